// File: rtl/seq_rca_addsub.sv
// Multi-cycle ripple-carry adder/subtractor.
// Each operation sums CHUNK bits per clock through a single registered carry,
// so one operation takes WIDTH/CHUNK BUSY cycles. Valid/ready handshakes sit on
// both the request side and the result side.
module seq_rca_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Reject parameter combinations that cannot be split into whole chunks.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("seq_rca_addsub: WIDTH must be >= 1");
        end
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_rca_addsub: CHUNK must be >= 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_split
            $error("seq_rca_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;       // Y, already inverted for subtract
    logic             c_q, c_d;         // carry between chunks
    logic [KW-1:0]    k_q, k_d;         // index of the chunk being summed
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] x_chunk, y_chunk;
    logic [CHUNK:0]   chunk_res;        // {carry out, chunk sum}
    logic             last_chunk;
    logic             accept;

    assign x_chunk    = xr_q[k_q*CHUNK +: CHUNK];
    assign y_chunk    = yr_q[k_q*CHUNK +: CHUNK];
    assign chunk_res  = {1'b0, x_chunk} + {1'b0, y_chunk} + {{CHUNK{1'b0}}, c_q};
    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    assign accept     = (state_q == IDLE) && in_valid;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            c_q     <= c_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept in IDLE, sweep the chunks, hold until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Datapath: subtract is X + ~Y + ~Cin, so the borrow-in becomes an
    // inverted carry-in and Cout reads as "no borrow".
    always_comb begin
        xr_d   = xr_q;
        yr_d   = yr_q;
        c_d    = c_q;
        k_d    = k_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (accept) begin
            xr_d   = X;
            yr_d   = sub ? ~Y : Y;
            c_d    = sub ? ~Cin : Cin;
            k_d    = '0;
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (state_q == BUSY) begin
            sum_d[k_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            c_d = chunk_res[CHUNK];
            k_d = k_q + KW'(1);
            if (last_chunk) begin
                cout_d = chunk_res[CHUNK];
                // Operands of equal sign producing a result of the other sign.
                ovf_d  = (xr_q[WIDTH-1] == yr_q[WIDTH-1]) &&
                         (chunk_res[CHUNK-1] != xr_q[WIDTH-1]);
            end
        end
    end

    // Handshake outputs are decoded straight from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_rca_addsub.sv
// Testbench for seq_rca_addsub: a default 16/4 instance and a bit-serial 4/1
// instance, checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_rca_addsub;

    logic        clk = 1'b0;
    logic        rst_n;

    // 16-bit, 4-bit chunks
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] X, Y, Sum;
    logic        Cin, sub, Cout, Ovf;

    // 4-bit, bit-serial
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  X4, Y4, Sum4;
    logic        Cin4, sub4, Cout4, Ovf4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_rca_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    seq_rca_addsub #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .X(X4), .Y(Y4), .Cin(Cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4)
    );

    typedef struct {
        logic [15:0] x, y;
        logic        cin, sb;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
    task automatic model(input int w, input int x, input int y, input int ci, input int sb,
                         output int s, output int co, output int ov);
        int m, r, sx, sy, sr;
        m  = 1 << w;
        r  = sb ? (x - y - ci) : (x + y + ci);
        s  = ((r % m) + m) % m;
        co = sb ? int'(x >= y + ci) : int'(r >= m);
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        sr = sb ? (sx - sy - ci) : (sx + sy + ci);
        ov = int'(sr >= m / 2 || sr < -(m / 2));
    endtask

    task automatic run16(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb, input logic early,
                         input logic [15:0] es, input logic eco, input logic eov);
        int lat;
        logic got;
        @(negedge clk);
        X = x; Y = y; Cin = ci; sub = sb; in_valid = 1'b1; out_ready = early;
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; X = $urandom; Y = $urandom;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = out_valid;
        end
        check({nm, ".latency"}, 32'(lat), 32'd4);
        if (got) begin
            check({nm, ".sum"},  32'(Sum),  32'(es));
            check({nm, ".cout"}, 32'(Cout), 32'(eco));
            check({nm, ".ovf"},  32'(Ovf),  32'(eov));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({nm, ".out_valid_drop"}, 32'(out_valid), 32'd0);
            check({nm, ".in_ready_back"},  32'(in_ready),  32'd1);
        end
    endtask

    task automatic run4(input string nm, input logic [3:0] x, input logic [3:0] y,
                        input logic ci, input logic sb,
                        input logic [3:0] es, input logic eco, input logic eov);
        int lat;
        logic got;
        @(negedge clk);
        X4 = x; Y4 = y; Cin4 = ci; sub4 = sb; in_valid4 = 1'b1;
        check({nm, ".in_ready"}, 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = out_valid4;
        end
        check({nm, ".latency"}, 32'(lat), 32'd4);
        if (got) begin
            check({nm, ".sum"},  32'(Sum4),  32'(es));
            check({nm, ".cout"}, 32'(Cout4), 32'(eco));
            check({nm, ".ovf"},  32'(Ovf4),  32'(eov));
            out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready4 = 1'b0;
            check({nm, ".in_ready_back"}, 32'(in_ready4), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[6];
        int   s, co, ov, lat;
        logic [15:0] rx, ry;
        logic        rc, rs, got;

        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0; Cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; X4 = '0; Y4 = '0; Cin4 = 1'b0; sub4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum",       32'(Sum),       32'd0);
        check("reset.cout",      32'(Cout),      32'd0);
        check("reset.ovf",       32'(Ovf),       32'd0);
        check("reset4.in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++)
            run16($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sb, 1'b0,
                  tbl[i].s, tbl[i].co, tbl[i].ov);

        // Bit-serial instance
        run4("bs_15p15p1", 4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
        run4("bs_1p12",    4'd1,  4'd12, 1'b0, 1'b0, 4'd13, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rx = 16'($urandom_range(0, 15)); ry = 16'($urandom_range(0, 15));
            rc = 1'($urandom); rs = 1'($urandom);
            model(4, int'(rx), int'(ry), int'(rc), int'(rs), s, co, ov);
            run4($sformatf("bs_rand%0d", i), rx[3:0], ry[3:0], rc, rs, 4'(s), co[0], ov[0]);
        end

        // Randomised operations, sometimes with out_ready raised early
        for (int i = 0; i < 30; i++) begin
            rx = 16'($urandom); ry = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            model(16, int'(rx), int'(ry), int'(rc), int'(rs), s, co, ov);
            run16($sformatf("rand%0d", i), rx, ry, rc, rs, 1'($urandom), 16'(s), co[0], ov[0]);
        end

        // Backpressure: result held while new requests are refused
        @(negedge clk);
        X = 16'h1234; Y = 16'h0FFF; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = out_valid;
        end
        check("bp.latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; X = 16'hAAAA; Y = 16'h5555;
            @(posedge clk); #1;
            check($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d.sum", i),       32'(Sum),       32'h2233);
            check($sformatf("bp%0d.in_ready", i),  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release_out_valid", 32'(out_valid), 32'd0);
        check("bp.release_in_ready",  32'(in_ready),  32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("bp.not_queued", 32'(out_valid), 32'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        X = 16'hFFFF; Y = 16'hFFFF; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.sum",       32'(Sum),       32'd0);
        check("rst_mid.in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid.no_result", 32'(out_valid), 32'd0);
        run16("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
